// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields from the requester,
// and the grant and registered read response back to it.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for the single-port data memory: fixed CPU priority with a bounded
// DMA starvation counter. Define DMEM_ARB_STATS_EN to build the contention counter.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         cpu,
  dmem_arbiter_if.slave         dma,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [15:0]           conflict_count
);

  localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {RSP_NONE, RSP_CPU, RSP_DMA} rsp_sel_t;

  logic [CNT_W-1:0]      starve_cnt;
  rsp_sel_t              rsp_sel;
  rsp_sel_t              rsp_next;
  logic                  cpu_gnt;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  // DMA wins when the CPU is idle or once it has been blocked STARVE_LIMIT cycles in a row.
  assign dma_gnt = dma.req & (~cpu.req | (starve_cnt == LIMIT));
  assign cpu_gnt = cpu.req & ~dma_gnt;

  assign cpu.gnt = cpu_gnt;
  assign dma.gnt = dma_gnt;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (dma_gnt) begin
      mem_read       = ~dma.we;
      mem_write      = dma.we;
      mem_address    = dma.addr;
      mem_write_data = dma.wdata;
    end else if (cpu_gnt) begin
      mem_read       = ~cpu.we;
      mem_write      = cpu.we;
      mem_address    = cpu.addr;
      mem_write_data = cpu.wdata;
    end
  end

  // A granted or withdrawn DMA request restarts the count; it cannot pass LIMIT because
  // at LIMIT a pending DMA request is always granted.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dma.req || dma_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rsp_next = RSP_NONE;
    if (dma_gnt && !dma.we) begin
      rsp_next = RSP_DMA;
    end else if (cpu_gnt && !cpu.we) begin
      rsp_next = RSP_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are two response registers, not a memory array, so they are reset to give clean rdata.
    if (!rst_n) begin
      rsp_sel     <= RSP_NONE;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      rsp_sel <= rsp_next;
      if (rsp_next == RSP_CPU) cpu_rdata_q <= mem_read_data;
      if (rsp_next == RSP_DMA) dma_rdata_q <= mem_read_data;
    end
  end

  assign cpu.rvalid = (rsp_sel == RSP_CPU);
  assign dma.rvalid = (rsp_sel == RSP_DMA);
  assign cpu.rdata  = cpu_rdata_q;
  assign dma.rdata  = dma_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (cpu.req && dma.req && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a memory model, a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_dmem_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int LIMIT = 4;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_bus ();
  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dma_bus ();

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic [15:0]   conflict_count;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu            (cpu_bus),
    .dma            (dma_bus),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .conflict_count (conflict_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    case (a)
      8'h00:   return 8'h42;
      8'h01:   return 8'h55;
      8'h10:   return 8'hAA;
      8'hFF:   return 8'h99;
      default: return 8'h00;
    endcase
  endfunction

  // Environment memory: asynchronous read gated by mem_read, write on the rising edge.
  logic [DW-1:0] ram [256];
  assign mem_read_data = mem_read ? ram[mem_address] : '0;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_write) ram[mem_address] = mem_write_data;
    end
  end

  // Reference model: per-transaction view of who is served, what memory holds,
  // and what each port must see one cycle after a granted read.
  logic [DW-1:0] model_mem [256];
  int            m_blocked;
  int            m_rsp;        // 0 none, 1 cpu, 2 dma
  logic [DW-1:0] m_cpu_rdata;
  logic [DW-1:0] m_dma_rdata;
  int            m_conflicts;

  function automatic logic model_dma_wins();
    return dma_bus.req && (!cpu_bus.req || m_blocked >= LIMIT);
  endfunction

  function automatic logic model_cpu_wins();
    return cpu_bus.req && !model_dma_wins();
  endfunction

  task automatic model_reset();
    m_blocked   = 0;
    m_rsp       = 0;
    m_cpu_rdata = '0;
    m_dma_rdata = '0;
    m_conflicts = 0;
  endtask

  task automatic model_step();
    logic dw, cw;
    dw = model_dma_wins();
    cw = model_cpu_wins();
    m_rsp = 0;
    if (dw) begin
      if (dma_bus.we) model_mem[dma_bus.addr] = dma_bus.wdata;
      else begin m_rsp = 2; m_dma_rdata = model_mem[dma_bus.addr]; end
    end else if (cw) begin
      if (cpu_bus.we) model_mem[cpu_bus.addr] = cpu_bus.wdata;
      else begin m_rsp = 1; m_cpu_rdata = model_mem[cpu_bus.addr]; end
    end
    m_blocked = (dma_bus.req && !dw) ? m_blocked + 1 : 0;
    if (STATS && cpu_bus.req && dma_bus.req && m_conflicts < 65535) m_conflicts++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic          e_cg, e_dg;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_rd, e_wr;
    e_dg = model_dma_wins();
    e_cg = model_cpu_wins();
    e_rd = (e_dg && !dma_bus.we) || (e_cg && !cpu_bus.we);
    e_wr = (e_dg && dma_bus.we) || (e_cg && cpu_bus.we);
    e_addr = e_dg ? dma_bus.addr : (e_cg ? cpu_bus.addr : '0);
    e_wd   = e_dg ? dma_bus.wdata : (e_cg ? cpu_bus.wdata : '0);
    check("cpu_gnt", cpu_bus.gnt, e_cg);
    check("dma_gnt", dma_bus.gnt, e_dg);
    check("mem_read", mem_read, e_rd);
    check("mem_write", mem_write, e_wr);
    check("mem_address", mem_address, e_addr);
    check("mem_write_data", mem_write_data, e_wd);
    check("cpu_rvalid", cpu_bus.rvalid, m_rsp == 1);
    check("dma_rvalid", dma_bus.rvalid, m_rsp == 2);
    check("cpu_rdata", cpu_bus.rdata, m_cpu_rdata);
    check("dma_rdata", dma_bus.rdata, m_dma_rdata);
    check("conflict_count", conflict_count, m_conflicts);
  end

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_bus.req = r; cpu_bus.we = w; cpu_bus.addr = a; cpu_bus.wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_bus.req = r; dma_bus.we = w; dma_bus.addr = a; dma_bus.wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_cpu(0, 0, 8'h00, 8'h00);
    set_dma(0, 0, 8'h00, 8'h00);

    // Reset state with both ports idle
    @(negedge clk);
    check("rst_cpu_rvalid", cpu_bus.rvalid, 1'b0);
    check("rst_dma_rvalid", dma_bus.rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_bus.rdata, 8'h00);
    check("rst_dma_rdata", dma_bus.rdata, 8'h00);
    check("rst_mem_ctl", {mem_read, mem_write, mem_address, mem_write_data}, 18'h0);
    check("rst_conflicts", conflict_count, 16'h0000);
    step();
    rst_n = 1'b1;

    // CPU read of 0x00
    set_cpu(1, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("rd0_gnt", cpu_bus.gnt, 1'b1);
    check("rd0_mem_read", mem_read, 1'b1);
    step();
    set_cpu(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("rd0_rvalid", cpu_bus.rvalid, 1'b1);
    check("rd0_rdata", cpu_bus.rdata, 8'h42);
    step();

    // CPU write 0x5A to 0x20, then read it back
    set_cpu(1, 1, 8'h20, 8'h5A);
    @(negedge clk);
    check("wr_mem_write", mem_write, 1'b1);
    check("wr_mem_read", mem_read, 1'b0);
    step();
    set_cpu(1, 0, 8'h20, 8'h00);
    @(negedge clk);
    check("wr_pulse_over", mem_write, 1'b0);
    check("wr_no_rvalid", cpu_bus.rvalid, 1'b0);
    step();
    set_cpu(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("rdback_rvalid", cpu_bus.rvalid, 1'b1);
    check("rdback_rdata", cpu_bus.rdata, 8'h5A);
    step();

    // Contention: both read 0x10 continuously -> CPU x4, DMA x1, repeating
    set_cpu(1, 0, 8'h10, 8'h00);
    set_dma(1, 0, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cont_cpu_gnt", cpu_bus.gnt, (i % 5) != 4);
      check("cont_dma_gnt", dma_bus.gnt, (i % 5) == 4);
      if (i == 0 || i == 5) check("cont_dma_rdata", dma_bus.rdata, (i == 5) ? 8'hAA : 8'h00);
      step();
    end
    set_cpu(0, 0, 8'h00, 8'h00);
    set_dma(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("cont_dma_rvalid", dma_bus.rvalid, 1'b1);
    check("cont_dma_rdata_last", dma_bus.rdata, 8'hAA);
    check("cont_conflicts", conflict_count, STATS ? 16'd10 : 16'd0);
    step();

    // DMA-only back-to-back reads
    set_dma(1, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("dstr_gnt0", dma_bus.gnt, 1'b1);
    step();
    set_dma(1, 0, 8'h01, 8'h00);
    @(negedge clk);
    check("dstr_gnt1", dma_bus.gnt, 1'b1);
    check("dstr_rdata0", dma_bus.rdata, 8'h42);
    step();
    set_dma(1, 0, 8'hFF, 8'h00);
    @(negedge clk);
    check("dstr_gnt2", dma_bus.gnt, 1'b1);
    check("dstr_rdata1", dma_bus.rdata, 8'h55);
    check("dstr_cpu_rvalid", cpu_bus.rvalid, 1'b0);
    step();
    set_dma(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("dstr_rvalid2", dma_bus.rvalid, 1'b1);
    check("dstr_rdata2", dma_bus.rdata, 8'h99);
    step();

    // DMA write, then CPU read of the same address
    set_dma(1, 1, 8'h40, 8'h33);
    @(negedge clk);
    check("dwr_mem_addr", mem_address, 8'h40);
    check("dwr_mem_wdata", mem_write_data, 8'h33);
    step();
    set_dma(0, 0, 8'h00, 8'h00);
    set_cpu(1, 0, 8'h40, 8'h00);
    step();
    set_cpu(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("dwr_cpu_rdata", cpu_bus.rdata, 8'h33);
    step();

    // Reset asserted in the cycle after a granted CPU read
    set_cpu(1, 0, 8'h01, 8'h00);
    step();
    set_cpu(0, 0, 8'h00, 8'h00);
    #2;
    check("mid_rvalid_before", cpu_bus.rvalid, 1'b1);
    check("mid_rdata_before", cpu_bus.rdata, 8'h55);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_async", cpu_bus.rvalid, 1'b0);
    check("mid_rdata_async", cpu_bus.rdata, 8'h00);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rvalid_after", cpu_bus.rvalid, 1'b0);
    step();
    @(negedge clk);
    check("mid_rvalid_after2", cpu_bus.rvalid, 1'b0);
    step();

    // Cancel: DMA blocked for two cycles then withdraws; counter must restart
    set_cpu(1, 0, 8'h20, 8'h00);
    set_dma(1, 0, 8'hFF, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("cancel_cpu_gnt", cpu_bus.gnt, 1'b1);
      step();
    end
    set_dma(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    step();
    set_dma(1, 0, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("recont_cpu_gnt", cpu_bus.gnt, i != 4);
      check("recont_dma_gnt", dma_bus.gnt, i == 4);
      step();
    end
    set_cpu(0, 0, 8'h00, 8'h00);
    set_dma(0, 0, 8'h00, 8'h00);
    @(negedge clk);
    check("recont_dma_rdata", dma_bus.rdata, 8'h99);
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port MAK-8 data memory between the CPU load/store unit and a DMA/debug loader port. Each cycle it selects at most one requester and drives the memory's `mem_read`/`mem_write`/`address`/`write_data` controls. It captures the memory's asynchronous read data into a per-requester registered response. The CPU has fixed priority, and a bounded starvation counter guarantees DMA forward progress. The block sits between the CPU datapath and `data_memory` in the top level.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, address width shared by both requesters and memory
- `DATA_WIDTH`, 8, data width
- `STARVE_LIMIT`, 4, consecutive blocked DMA cycles before DMA wins; legal range 1–255

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `cpu_req`  in  1  CPU access request; held with its fields until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_WIDTH  CPU address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_gnt`  out  1  combinational grant; `cpu_req & cpu_gnt` at a rising edge = transfer
- `cpu_rvalid`  out  1  one-cycle pulse; `cpu_rdata` valid
- `cpu_rdata`  out  DATA_WIDTH  registered read data
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`: same widths and meanings as the CPU group, for the DMA port
- `mem_read`  out  1  to memory read enable
- `mem_write`  out  1  to memory write enable
- `mem_address`  out  ADDR_WIDTH  to memory address
- `mem_write_data`  out  DATA_WIDTH  to memory write data
- `mem_read_data`  in  DATA_WIDTH  from memory; asynchronous, 0 when `mem_read` = 0
- `conflict_count`  out  16  cycles in which both requesters asserted `req`; see Configuration

## Operation
- `starve_cnt` has width `$clog2(STARVE_LIMIT+1)`. It drives the grant decision, which is combinational:
  - `dma_req & (!cpu_req | starve_cnt == STARVE_LIMIT)` → DMA granted.
  - Otherwise `cpu_req` → CPU granted.
  - Otherwise no grant.
- At most one of `cpu_gnt`/`dma_gnt` is high in any cycle.
- Memory controls are a mux of the granted requester:
  - `mem_read = gnt & !we`, `mem_write = gnt & we`.
  - `mem_read` and `mem_write` are never both 1. The memory drops writes when both are set, so this is mandatory.
- With no grant, all `mem_*` outputs are 0.
- `starve_cnt` update at each rising edge:
  - reset to 0 when `dma_gnt`, or when `!dma_req`;
  - incremented when `dma_req & !dma_gnt`;
  - never exceeds `STARVE_LIMIT`.
- Response state register `rsp_sel` ∈ {NONE, CPU, DMA}:
  - set to the granted port on a granted read; NONE otherwise.
  - In that same edge, `mem_read_data` is captured into the granted port's `rdata`.
  - The other port's `rdata` holds its value.
- `cpu_rvalid = (rsp_sel == CPU)`; `dma_rvalid = (rsp_sel == DMA)`.
- Writes produce no response.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces:
  - `starve_cnt` = 0, `rsp_sel` = NONE;
  - both `rdata` = 0, both `rvalid` = 0;
  - `conflict_count` = 0.
- `gnt` and `mem_*` are combinational from inputs and state. During reset they follow `req`, with `starve_cnt` = 0.
- Read latency: request granted in cycle N → `rvalid` high and `rdata` valid in cycle N+1, for exactly one cycle.
- Write: committed to memory at the rising edge ending the grant cycle.
- Throughput: one access per cycle. Back-to-back reads from the same port give `rvalid` on consecutive cycles.
- Requester rule: `req`, `we`, `addr`, `wdata` stay stable until `gnt`. Deasserting `req` before grant is legal and cancels the request.
- Simultaneous requests: the CPU wins for `STARVE_LIMIT` cycles, then the DMA wins exactly one cycle, then the counter restarts at 0.
- Reset asserted mid-access: any pending read response is discarded. No `rvalid` appears after reset release.

## Configuration
- `DMEM_ARB_STATS_EN` defined:
  - `conflict_count` increments on each rising edge with `cpu_req & dma_req`;
  - saturates at 16'hFFFF;
  - cleared only by reset.
- `DMEM_ARB_STATS_EN` undefined: `conflict_count` is tied to 16'h0000 and no counter logic is synthesized.

## Test plan
- Reset: hold `rst_n` = 0 with both `req` = 0 → all `rvalid`/`rdata`/`mem_*` = 0 and `conflict_count` = 0. Release reset, then CPU reads 8'h00 → `cpu_rvalid` = 1 with `cpu_rdata` = 8'h42 one cycle later.
- CPU write 8'h5A to 8'h20, then CPU read of 8'h20 → `mem_write` pulses for one cycle with `mem_read` = 0; `cpu_rdata` = 8'h5A on the following `rvalid`.
- Contention with `STARVE_LIMIT` = 4: both ports continuously request reads of 8'h10 → grants follow CPU ×4, DMA ×1, repeating. `dma_rdata` = 8'hAA on each `dma_rvalid`. With `DMEM_ARB_STATS_EN`, `conflict_count` equals the number of contention cycles.
- DMA-only stream: DMA reads 8'h00, 8'h01, 8'hFF back-to-back → `dma_gnt` is high every cycle; `dma_rdata` = 8'h42, 8'h55, 8'h99 on consecutive cycles; `cpu_rvalid` stays 0.
- Reset mid-access: assert `rst_n` = 0 asynchronously in the cycle after a granted CPU read → `cpu_rvalid` and `cpu_rdata` go to 0 immediately, and no response appears after release.
- Cancel: DMA raises `req` while blocked by the CPU for 2 cycles, then drops it → `starve_cnt` returns to 0; a later contention still gives the CPU 4 grants first.
